dmem_resp: RTL and testbench

Data-memory responder for the pipelined ARM core: it is the far end of the Memory-stage load/store interface, i.e. it consumes the address and store data the datapath drives in M and returns load data. It models a word-organised RAM with a fixed, parameterised access latency, supports word and byte (LDRB/STRB) accesses, and raises a busy signal that the hazard unit turns into a full-pipeline stall until the access completes. The request-side signals stay stable while busy is high.

---
 rtl/dmem_pkg.sv | 53 +++++
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_resp.sv | 172 +++++++++++++++++
 tb/tb_dmem_resp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the Memory-stage data responder.
//   state_e      : responder FSM states (IDLE, WAIT, DONE)
//   LANE_*       : byte-lane select values taken from ALUOutM[1:0]
//   byte_enable  : 4-bit write enable for a given access size and lane
//   lane_byte    : extracts one little-endian byte lane from a word
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] LANE_0 = 2'd0;  // bits [7:0]
  localparam logic [1:0] LANE_1 = 2'd1;  // bits [15:8]
  localparam logic [1:0] LANE_2 = 2'd2;  // bits [23:16]
  localparam logic [1:0] LANE_3 = 2'd3;  // bits [31:24]

  // A misaligned word access yields an all-zero enable, which is how such a
  // store gets suppressed without any extra gating at the array.
  function automatic logic [3:0] byte_enable(input logic is_byte,
                                             input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    if (is_byte) begin
      unique case (lane)
        LANE_0:  be = 4'b0001;
        LANE_1:  be = 4'b0010;
        LANE_2:  be = 4'b0100;
        default: be = 4'b1000;
      endcase
    end else if (lane == LANE_0) begin
      be = 4'b1111;
    end
    return be;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                           input logic [1:0]  lane);
    logic [7:0] b;
    unique case (lane)
      LANE_0:  b = word[7:0];
      LANE_1:  b = word[15:8];
      LANE_2:  b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit word RAM with byte-enabled synchronous write and
// asynchronous (combinational) read.
//   clk      in   write clock
//   i_we     in   write strobe
//   i_be     in   per-byte write enable, bit b covers bits [8b+7:8b]
//   i_addr   in   word index
//   i_wdata  in   write data (already lane-replicated by the caller)
//   o_rdata  out  word at i_addr
// -----------------------------------------------------------------------------
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // NOTE: the storage array has no reset branch on purpose; clearing a RAM
  // would force it into flops and the contents are defined as uninitialised.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
// Far end of the M-stage load/store interface. Each request is latched in
// IDLE, waits LATENCY cycles in WAIT, is performed on the WAIT->DONE edge and
// presented in DONE. MemBusyM stalls the pipeline from the request cycle
// until DONE, so each access costs LATENCY+1 stall cycles.
//   clk         in   pipeline clock
//   reset       in   synchronous, active-high
//   MemReadM    in   load request
//   MemWriteM   in   store request (wins over MemReadM)
//   ByteM       in   byte access when high, word access when low
//   ALUOutM     in   byte address
//   WriteDataM  in   store data; byte stores use [7:0]
//   ReadDataM   out  registered load data
//   MemBusyM    out  stall request
//   MemErrM     out  one-cycle pulse in DONE for a misaligned word access
// -----------------------------------------------------------------------------
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM,
  output logic        MemErrM
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e        r_state;
  state_e        w_next;
  logic [3:0]    r_cnt;
  logic          r_is_store;
  logic          r_is_byte;
  logic [AW-1:0] r_index;
  logic [1:0]    r_lane;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_req;
  logic          w_busy;
  logic          w_accept;
  logic          w_commit;
  logic          w_misaligned;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rword;
  logic [31:0]   w_load;

  assign w_req        = MemReadM | MemWriteM;
  assign w_accept     = (r_state == IDLE) & w_req;
  assign w_commit     = (r_state == WAIT) & (r_cnt == 4'd0);
  assign w_misaligned = ~r_is_byte & (r_lane != LANE_0);

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state / busy decode
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_busy = 1'b1;
          w_next = WAIT;
        end
      end
      WAIT: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next = DONE;
        end
      end
      DONE: begin
        // Pipeline advances this cycle; a request present now is the one
        // just served, so it is deliberately not examined.
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Busy is forced low during reset even if a request is still asserted.
  assign MemBusyM = w_busy & ~reset;

  // ---------------------------------------------------------------------------
  // Request latch, wait counter, result and error registers
  // ---------------------------------------------------------------------------
  // The request latches carry no reset: they are always loaded in IDLE before
  // anything consumes them.
  always_ff @(posedge clk) begin
    if (w_accept && !reset) begin
      r_is_store <= MemWriteM;
      r_is_byte  <= ByteM;
      r_index    <= ALUOutM[AW+1:2];
      r_lane     <= ALUOutM[1:0];
      r_wdata    <= WriteDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_cnt <= CNT_INIT;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err <= w_misaligned;
        if (!r_is_store) begin
          r_rdata <= w_load;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array and access datapath
  // ---------------------------------------------------------------------------
  // Replicating the low byte lets the array use one lane-aligned data bus for
  // both sizes; the byte enable picks the lane that actually changes.
  assign w_wdata = r_is_byte ? {4{r_wdata[7:0]}} : r_wdata;
  assign w_be    = byte_enable(r_is_byte, r_lane);
  // Reset on the commit edge drops the pending store.
  assign w_we    = w_commit & r_is_store & ~reset;

  // A misaligned word load still returns the aligned word.
  assign w_load  = r_is_byte ? {24'h0, lane_byte(w_rword, r_lane)} : w_rword;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (r_index),
    .i_wdata (w_wdata),
    .o_rdata (w_rword)
  );

  assign ReadDataM = r_rdata;
  assign MemErrM   = r_err;

endmodule

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp
// Self-checking bench for dmem_resp (DEPTH=64, LATENCY=2): directed vector
// table, hand-written reset-mid-access sequences, and a randomized phase
// compared against a word-array reference model.
// -----------------------------------------------------------------------------
module tb_dmem_resp;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic        ByteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemBusyM;
  logic        MemErrM;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          by;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [16];

  dmem_resp #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ByteM      (ByteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .MemBusyM   (MemBusyM),
    .MemErrM    (MemErrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request at a negedge, counts busy cycles, samples the DONE
  // cycle, then samples the following idle cycle.
  task automatic do_access(input bit rd, input bit wr, input bit by,
                           input logic [31:0] addr, input logic [31:0] data,
                           input bit scramble,
                           output logic [31:0] rdata, output logic err,
                           output int busy_n, output bit err_early,
                           output logic err_after);
    @(negedge clk);
    MemReadM   = rd;
    MemWriteM  = wr;
    ByteM      = by;
    ALUOutM    = addr;
    WriteDataM = data;
    #1;
    busy_n    = 0;
    err_early = 1'b0;
    while (MemBusyM === 1'b1 && busy_n < 40) begin
      busy_n++;
      if (MemErrM !== 1'b0) err_early = 1'b1;
      @(negedge clk);
      if (scramble) begin
        ALUOutM    = $urandom;
        WriteDataM = $urandom;
        ByteM      = 1'($urandom_range(0, 1));
      end
      #1;
    end
    rdata     = ReadDataM;
    err       = MemErrM;
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    @(negedge clk);
    #1;
    err_after = MemErrM;
  endtask

  task automatic run_check(input string name, input bit rd, input bit wr,
                           input bit by, input logic [31:0] addr,
                           input logic [31:0] data, input bit scramble,
                           input logic [31:0] exp_rdata, input bit exp_err);
    logic [31:0] rdata;
    logic        err, err_after;
    int          busy_n;
    bit          err_early;
    do_access(rd, wr, by, addr, data, scramble, rdata, err, busy_n,
              err_early, err_after);
    check({name, " busy_cycles"}, busy_n, LATENCY + 1);
    check({name, " rdata"}, rdata, exp_rdata);
    check({name, " err"}, {31'h0, err}, {31'h0, exp_err});
    check({name, " err_early"}, {31'h0, err_early}, 32'h0);
    check({name, " err_after"}, {31'h0, err_after}, 32'h0);
  endtask

  // Reference model: word array with little-endian lanes.
  task automatic model_access(input bit rd, input bit wr, input bit by,
                              input logic [31:0] addr, input logic [31:0] data,
                              output bit exp_err);
    int idx;
    int lane;
    logic [31:0] w;
    idx  = int'((addr >> 2) % DEPTH);
    lane = int'(addr & 32'h3);
    exp_err = !by && lane != 0;
    if (wr) begin
      if (by) model_mem[idx][8*lane +: 8] = data[7:0];
      else if (lane == 0) model_mem[idx] = data;
    end else if (rd) begin
      w = model_mem[idx];
      model_rd = by ? ((w >> (8 * lane)) & 32'hFF) : w;
    end
  endtask

  initial begin
    logic [31:0] rd_now;
    bit          e_err;

    //          rd wr by  addr          data          exp_rdata     err
    vecs[0]  = '{0, 1, 0, 32'h10,      32'hDEADBEEF, 32'h00000000, 0};
    vecs[1]  = '{1, 0, 0, 32'h10,      32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{0, 1, 0, 32'h20,      32'h0,        32'hDEADBEEF, 0};
    vecs[3]  = '{0, 1, 1, 32'h21,      32'h11,       32'hDEADBEEF, 0};
    vecs[4]  = '{0, 1, 1, 32'h23,      32'h22,       32'hDEADBEEF, 0};
    vecs[5]  = '{1, 0, 0, 32'h20,      32'h0,        32'h22001100, 0};
    vecs[6]  = '{1, 0, 1, 32'h23,      32'h0,        32'h00000022, 0};
    vecs[7]  = '{0, 1, 0, 32'h04,      32'hCAFEF00D, 32'h00000022, 0};
    vecs[8]  = '{0, 1, 0, 32'h06,      32'h12345678, 32'h00000022, 1};
    vecs[9]  = '{1, 0, 0, 32'h04,      32'h0,        32'hCAFEF00D, 0};
    vecs[10] = '{0, 1, 0, 32'h100,     32'h12345678, 32'hCAFEF00D, 0};
    vecs[11] = '{1, 0, 0, 32'h000,     32'h0,        32'h12345678, 0};
    vecs[12] = '{1, 1, 0, 32'h40,      32'hA5A5A5A5, 32'h12345678, 0};
    vecs[13] = '{1, 0, 0, 32'h40,      32'h0,        32'hA5A5A5A5, 0};
    vecs[14] = '{1, 0, 0, 32'h42,      32'h0,        32'hA5A5A5A5, 1};
    vecs[15] = '{1, 0, 1, 32'h11,      32'h0,        32'h000000BE, 0};

    reset      = 1'b1;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ByteM      = 1'b0;
    ALUOutM    = 32'h0;
    WriteDataM = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset busy", {31'h0, MemBusyM}, 32'h0);
    check("reset rdata", ReadDataM, 32'h0);
    check("reset err", {31'h0, MemErrM}, 32'h0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].by,
                vecs[i].addr, vecs[i].data, 1'b0, vecs[i].exp_rdata,
                vecs[i].exp_err);
    end

    // Reset during WAIT of a store to 0x30 that holds 0; reset lands on the
    // first WAIT cycle (k=1) and on the commit cycle (k=2).
    for (int k = 1; k <= 2; k++) begin
      run_check($sformatf("rst%0d pre_store", k), 0, 1, 0, 32'h30, 32'h0,
                1'b0, (k == 1) ? 32'h000000BE : 32'h0, 0);
      @(negedge clk);
      MemWriteM  = 1'b1;
      ALUOutM    = 32'h30;
      WriteDataM = 32'hFFFFFFFF;
      repeat (k) @(negedge clk);
      reset = 1'b1;
      #1;
      check($sformatf("rst%0d busy_in_reset", k), {31'h0, MemBusyM}, 32'h0);
      @(negedge clk);
      #1;
      check($sformatf("rst%0d busy_after", k), {31'h0, MemBusyM}, 32'h0);
      check($sformatf("rst%0d rdata_after", k), ReadDataM, 32'h0);
      reset     = 1'b0;
      MemWriteM = 1'b0;
      run_check($sformatf("rst%0d reload", k), 1, 0, 0, 32'h30, 32'h0, 1'b0,
                32'h0, 0);
    end

    // Randomized phase: define every word first, then random traffic with
    // request-side inputs scrambled while busy.
    model_rd = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_now = $urandom;
      model_access(0, 1, 0, 32'(i * 4), rd_now, e_err);
      run_check($sformatf("init%0d", i), 0, 1, 0, 32'(i * 4), rd_now, 1'b0,
                model_rd, e_err);
    end
    for (int i = 0; i < 150; i++) begin
      bit          rd, wr, by, scr;
      logic [31:0] addr, data;
      wr   = ($urandom_range(0, 2) == 0);
      rd   = !wr || ($urandom_range(0, 3) == 0);
      by   = 1'($urandom_range(0, 1));
      scr  = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = by ? addr[1:0] : 2'b00;
      data = $urandom;
      model_access(rd, wr, by, addr, data, e_err);
      run_check($sformatf("rand%0d", i), rd, wr, by, addr, data, scr,
                model_rd, e_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
